// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 dual-port memory responder.
// LC3_MEM_RANDLAT_EN (optional) selects LFSR-randomised wait states in lc3_mem_port_fsm.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_WAIT = 2'd1,
    PS_DONE = 2'd2
  } port_state_e;

  typedef logic [3:0] lat_t;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h3000;

  // x^16 + x^14 + x^13 + x^11 + 1, taken from bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS       = 16'hB400;
  localparam logic [15:0] LFSR_SEED_INSTR = 16'hACE1;
  localparam logic [15:0] LFSR_SEED_DATA  = 16'h1D2B;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// One memory port sequencer: IDLE -> WAIT (wait states) -> DONE (completion pulse) -> IDLE.
// LC3_MEM_RANDLAT_EN draws the wait count from a per-port LFSR instead of the fixed LAT.
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
#(
  parameter int          LAT  = 0,
  parameter logic [15:0] SEED = LFSR_SEED_INSTR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       block,
  output logic       accept,
  output logic       access,
  output logic       complete,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE = PS_IDLE;
  localparam logic [1:0] S_WAIT = PS_WAIT;
  localparam logic [1:0] S_DONE = PS_DONE;

  logic [1:0] state_q;
  lat_t       cnt_q;
  lat_t       wait_cycles;

  // Handshake: req is sampled only in IDLE and only when block is low; accept marks the
  // sampling edge, access marks the edge the array is touched, complete is high for the
  // single cycle spent in DONE.
  assign accept   = (state_q == S_IDLE) && req && !block;
  assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign complete = (state_q == S_DONE);
  assign state    = state_q;

`ifdef LC3_MEM_RANDLAT_EN
  localparam logic [4:0] MODULUS = 5'(LAT + 1);

  logic [15:0] lfsr_q;

  assign wait_cycles = lat_t'({1'b0, lfsr_q[3:0]} % MODULUS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else if (accept) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end
`else
  assign wait_cycles = lat_t'(LAT);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_WAIT;
            cnt_q   <= wait_cycles;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Dual-port (fetch + data) memory responder for LC3 with per-port wait states and a backdoor loader.
// Optional macro LC3_MEM_RANDLAT_EN randomises each port's wait count within 0..LAT.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                INSTR_LAT = 0,
  parameter int                DATA_LAT  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instrmem_rd,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              Data_en,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              addr_err
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              instr_accept, instr_access;
  logic              data_accept, data_access;
  logic [1:0]        instr_state, data_state;
  logic              both_idle, load_block;

  logic [ADDR_W-1:0] instr_addr_q, data_addr_q;
  logic              data_rd_q;
  logic [DATA_W-1:0] data_din_q;

  logic [ADDR_W-1:0] instr_off, data_off, load_off;
  logic [IDX_W-1:0]  instr_idx, data_idx, load_idx;
  logic              instr_mapped, data_mapped, load_mapped;

  function automatic logic in_range(input logic [ADDR_W-1:0] off);
    return 32'(off) < DEPTH_U;
  endfunction

  // Offsets wrap modulo 2^ADDR_W, so addresses below BASE_ADDR land far out of range.
  assign instr_off    = instr_addr_q - BASE_ADDR;
  assign data_off     = data_addr_q - BASE_ADDR;
  assign load_off     = load_addr - BASE_ADDR;
  assign instr_idx    = instr_off[IDX_W-1:0];
  assign data_idx     = data_off[IDX_W-1:0];
  assign load_idx     = load_off[IDX_W-1:0];
  assign instr_mapped = in_range(instr_off);
  assign data_mapped  = in_range(data_off);
  assign load_mapped  = in_range(load_off);

  // A load only lands when both ports are idle, and then it also holds off idle requests for a cycle.
  assign both_idle  = (instr_state == PS_IDLE) && (data_state == PS_IDLE);
  assign load_block = load_en && both_idle;

  lc3_mem_port_fsm #(
    .LAT  (INSTR_LAT),
    .SEED (LFSR_SEED_INSTR)
  ) u_instr_fsm (
    .clock    (clock),
    .reset    (reset),
    .req      (instrmem_rd),
    .block    (load_block),
    .accept   (instr_accept),
    .access   (instr_access),
    .complete (complete_instr),
    .state    (instr_state)
  );

  lc3_mem_port_fsm #(
    .LAT  (DATA_LAT),
    .SEED (LFSR_SEED_DATA)
  ) u_data_fsm (
    .clock    (clock),
    .reset    (reset),
    .req      (Data_en),
    .block    (load_block),
    .accept   (data_accept),
    .access   (data_access),
    .complete (complete_data),
    .state    (data_state)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Instr_dout   <= '0;
      Data_dout    <= '0;
      addr_err     <= 1'b0;
      instr_addr_q <= '0;
      data_addr_q  <= '0;
      data_rd_q    <= 1'b0;
      data_din_q   <= '0;
    end else begin
      addr_err <= (instr_access && !instr_mapped) || (data_access && !data_mapped);
      if (instr_accept) begin
        instr_addr_q <= pc;
      end
      if (data_accept) begin
        data_addr_q <= Data_addr;
        data_rd_q   <= Data_rd;
        data_din_q  <= Data_din;
      end
      if (instr_access) begin
        Instr_dout <= instr_mapped ? mem[instr_idx] : '0;
      end
      if (data_access && data_rd_q) begin
        Data_dout <= data_mapped ? mem[data_idx] : '0;
      end
    end
  end

  // Array is never cleared; a same-edge fetch of a location being written sees the old word.
  always_ff @(posedge clock) begin
    if (data_access && !data_rd_q && data_mapped) begin
      mem[data_idx] <= data_din_q;
    end else if (load_block && load_mapped) begin
      mem[load_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: dut_a (INSTR_LAT=2, DATA_LAT=0) and dut_b (INSTR_LAT=7, DATA_LAT=3).
// With LC3_MEM_RANDLAT_EN defined only the reset checks and the dut_b latency sweep run.
module tb_lc3_mem_responder;

  logic        clock;
  logic        reset;

  logic [15:0] pc, Data_addr, Data_din, load_addr, load_data;
  logic        instrmem_rd, Data_en, Data_rd, load_en;
  logic [15:0] Instr_dout, Data_dout;
  logic        complete_instr, complete_data, addr_err;

  logic [15:0] b_pc, b_data_addr, b_data_din, b_load_addr, b_load_data;
  logic        b_instrmem_rd, b_data_en, b_data_rd, b_load_en;
  logic [15:0] b_instr_dout, b_data_dout;
  logic        b_complete_instr, b_complete_data, b_addr_err;

  int          total  = 0;
  int          passed = 0;
  logic [15:0] exp_q[$];

  lc3_mem_responder #(.INSTR_LAT(2), .DATA_LAT(0)) dut_a (
    .clock(clock), .reset(reset),
    .pc(pc), .instrmem_rd(instrmem_rd), .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .Data_en(Data_en), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(Data_dout), .complete_data(complete_data),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .addr_err(addr_err)
  );

  lc3_mem_responder #(.INSTR_LAT(7), .DATA_LAT(3)) dut_b (
    .clock(clock), .reset(reset),
    .pc(b_pc), .instrmem_rd(b_instrmem_rd), .Instr_dout(b_instr_dout),
    .complete_instr(b_complete_instr),
    .Data_en(b_data_en), .Data_rd(b_data_rd), .Data_addr(b_data_addr), .Data_din(b_data_din),
    .Data_dout(b_data_dout), .complete_data(b_complete_data),
    .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data), .addr_err(b_addr_err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic b_load_word(input logic [15:0] a, input logic [15:0] d);
    b_load_en = 1'b1; b_load_addr = a; b_load_data = d;
    tick();
    b_load_en = 1'b0;
  endtask

  // Latency is counted in edges from the sampling edge to the one after which complete is seen.
  task automatic fetch(input logic [15:0] addr, input int exp_lat, input logic exp_err);
    int          n;
    logic        seen;
    logic [15:0] e;
    pc = addr; instrmem_rd = 1'b1; n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      load_en = 1'b0;
      n++;
      if (complete_instr) seen = 1'b1;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
    check("instr_lat", 32'(n), 32'(exp_lat));
    check("instr_dout", 32'(Instr_dout), 32'(e));
    check("instr_err", 32'(addr_err), 32'(exp_err));
    tick();
    check("instr_pulse", 32'(complete_instr), 0);
    check("instr_hold", 32'(Instr_dout), 32'(e));
    check("instr_err_clr", 32'(addr_err), 0);
    instrmem_rd = 1'b0;
  endtask

  task automatic data_op(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                         input int exp_lat, input logic [15:0] exp_dout, input logic exp_err);
    int   n;
    logic seen;
    Data_en = 1'b1; Data_rd = rd; Data_addr = addr; Data_din = din; n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (complete_data) seen = 1'b1;
    end
    check("data_lat", 32'(n), 32'(exp_lat));
    check("data_dout", 32'(Data_dout), 32'(exp_dout));
    check("data_err", 32'(addr_err), 32'(exp_err));
    Data_en = 1'b0;
    tick();
    check("data_pulse", 32'(complete_data), 0);
  endtask

  task automatic b_fetch(input logic [15:0] addr, output int lat, output logic [15:0] dout);
    int   n;
    logic seen;
    b_pc = addr; b_instrmem_rd = 1'b1; n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (b_complete_instr) seen = 1'b1;
    end
    lat = n; dout = b_instr_dout;
    b_instrmem_rd = 1'b0;
    tick();
  endtask

  task automatic b_read(input logic [15:0] addr, output int lat, output logic [15:0] dout);
    int   n;
    logic seen;
    b_data_en = 1'b1; b_data_rd = 1'b1; b_data_addr = addr; n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (b_complete_data) seen = 1'b1;
    end
    lat = n; dout = b_data_dout;
    b_data_en = 1'b0;
    tick();
  endtask

  initial begin
    int          lat;
    int          n_fetch;
    logic [15:0] dout;
    logic [15:0] seen_lat;

    reset = 1'b0;
    pc = '0; instrmem_rd = 1'b0; Data_en = 1'b0; Data_rd = 1'b0; Data_addr = '0; Data_din = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    b_pc = '0; b_instrmem_rd = 1'b0; b_data_en = 1'b0; b_data_rd = 1'b0; b_data_addr = '0;
    b_data_din = '0; b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0;
    seen_lat = '0;

    repeat (3) tick();
    check("rst_ci", 32'(complete_instr), 0);
    check("rst_cd", 32'(complete_data), 0);
    check("rst_idout", 32'(Instr_dout), 0);
    check("rst_ddout", 32'(Data_dout), 0);
    check("rst_err", 32'(addr_err), 0);
    check("rst_b_ci", 32'(b_complete_instr), 0);
    reset = 1'b1;
    tick();

`ifndef LC3_MEM_RANDLAT_EN
    load_word(16'h3000, 16'h1234);
    load_word(16'h3001, 16'hABCD);
    load_word(16'h3010, 16'h0AAA);
    load_word(16'h3020, 16'h7777);
    load_word(16'h3030, 16'h0C0C);

    // basic fetch: complete after the 4th edge, output held afterwards
    exp_q.push_back(16'h1234);
    fetch(16'h3000, 4, 1'b0);

    // data write/read; a write leaves Data_dout alone
    data_op(1'b0, 16'h3005, 16'hBEEF, 2, 16'h0000, 1'b0);
    data_op(1'b1, 16'h3005, 16'h0000, 2, 16'hBEEF, 1'b0);
    data_op(1'b0, 16'h3005, 16'h1111, 2, 16'hBEEF, 1'b0);
    data_op(1'b1, 16'h3005, 16'h0000, 2, 16'h1111, 1'b0);

    // unmapped addresses on both sides of the window
    exp_q.push_back(16'h0000);
    fetch(16'h2FFF, 4, 1'b1);
    exp_q.push_back(16'h1234);
    fetch(16'h3000, 4, 1'b0);
    exp_q.push_back(16'h0000);
    fetch(16'h3400, 4, 1'b1);
    data_op(1'b0, 16'h3400, 16'h5A5A, 2, 16'h1111, 1'b1);
    exp_q.push_back(16'h1234);
    fetch(16'h3000, 4, 1'b0);
    data_op(1'b1, 16'h2FFF, 16'h0000, 2, 16'h0000, 1'b1);

    // data write and fetch of the same word finishing on the same edge
    pc = 16'h3010; instrmem_rd = 1'b1;
    tick(); tick();
    Data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3010; Data_din = 16'h5555;
    tick(); tick();
    check("coll_ci", 32'(complete_instr), 1);
    check("coll_cd", 32'(complete_data), 1);
    check("coll_old", 32'(Instr_dout), 'h0AAA);
    instrmem_rd = 1'b0; Data_en = 1'b0;
    tick();
    check("coll_ci_clr", 32'(complete_instr), 0);
    exp_q.push_back(16'h5555);
    fetch(16'h3010, 4, 1'b0);

    // load beats a same-cycle idle fetch, which starts one edge later and sees the new word
    load_en = 1'b1; load_addr = 16'h3001; load_data = 16'h4321;
    exp_q.push_back(16'h4321);
    fetch(16'h3001, 5, 1'b0);

    // load while the data port is busy is dropped
    Data_en = 1'b1; Data_rd = 1'b1; Data_addr = 16'h3030;
    tick();
    load_en = 1'b1; load_addr = 16'h3030; load_data = 16'hDEAD;
    tick();
    load_en = 1'b0;
    check("busy_cd", 32'(complete_data), 1);
    check("busy_dout", 32'(Data_dout), 'h0C0C);
    Data_en = 1'b0;
    tick();
    data_op(1'b1, 16'h3030, 16'h0000, 2, 16'h0C0C, 1'b0);

    // reset during the WAIT of a write abandons it
    Data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3020; Data_din = 16'h9999;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_idout", 32'(Instr_dout), 0);
    check("mid_rst_ddout", 32'(Data_dout), 0);
    check("mid_rst_cd", 32'(complete_data), 0);
    Data_en = 1'b0;
    tick(); tick();
    check("mid_rst_cd2", 32'(complete_data), 0);
    reset = 1'b1;
    tick();
    check("post_rst_cd", 32'(complete_data), 0);
    data_op(1'b1, 16'h3020, 16'h0000, 2, 16'h7777, 1'b0);
`endif

    // dut_b: longer latencies (random within range when the macro is defined)
    for (int i = 0; i < 4; i++) begin
      b_load_word(16'h3000 + 16'(i), 16'hA000 + 16'(i) * 16'h0111);
    end
`ifdef LC3_MEM_RANDLAT_EN
    n_fetch = 1000;
`else
    n_fetch = 20;
`endif
    for (int i = 0; i < n_fetch; i++) begin
      b_fetch(16'h3000 + 16'(i % 4), lat, dout);
      check("b_dout", 32'(dout), 32'(16'hA000 + 16'(i % 4) * 16'h0111));
`ifdef LC3_MEM_RANDLAT_EN
      check("b_lat_range", 32'(lat >= 2 && lat <= 9), 1);
      if (lat < 16) seen_lat[lat] = 1'b1;
`else
      check("b_lat", 32'(lat), 9);
`endif
    end
`ifdef LC3_MEM_RANDLAT_EN
    check("b_lat_cover", 32'(seen_lat[9:2]), 'hFF);
`endif

    b_read(16'h3002, lat, dout);
    check("b_rd_dout", 32'(dout), 'hA222);
`ifdef LC3_MEM_RANDLAT_EN
    check("b_rd_lat_range", 32'(lat >= 2 && lat <= 5), 1);
`else
    check("b_rd_lat", 32'(lat), 5);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
